// File: rtl/load_store_unit_if.sv
// load_store_unit_if: core-side request/response bus and data_memory port bundle for the LSU
interface lsu_req_if;
    logic        valid;
    logic        ready;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    modport master (output valid, we, funct3, addr, wdata, input ready, resp_valid, resp_rdata, resp_err);
    modport slave  (input valid, we, funct3, addr, wdata, output ready, resp_valid, resp_rdata, resp_err);
endinterface

interface lsu_mem_if;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    modport master (output we, addr, wdata, input rdata);
    modport slave  (input we, addr, wdata, output rdata);
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I byte-addressed loads/stores onto a word-indexed, whole-word-write data memory
// Define LSU_MISALIGN_ERR_EN to fault misaligned halfword/word accesses instead of ignoring low address bits.
module load_store_unit #(
    parameter int MEM_WORDS = 256
) (
    input  logic      clk_i,
    input  logic      rst_i,
    lsu_req_if.slave  req,
    lsu_mem_if.master mem
);
    typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;
    state_t      state, state_nx;
    logic        we_q, err_q;
    logic [2:0]  f3_q;
    logic [29:0] idx_q;
    logic [1:0]  lane_q, lane;
    logic [31:0] wd_q, rdata_q;
    logic        accept, bad, misalign, bad_f3, out_of_range;
    logic [31:0] shifted, ext, rep, bmask, merged;
    logic [3:0]  bmask_b;

    assign accept = req.valid && req.ready;
`ifdef LSU_MISALIGN_ERR_EN
    assign misalign = (req.funct3[1:0] == 2'b01 && req.addr[0]) ||
                      (req.funct3[1:0] == 2'b10 && req.addr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif
    assign bad_f3       = req.we ? (req.funct3 > 3'b010) : (req.funct3 == 3'b011 || req.funct3[2:1] == 2'b11);
    assign out_of_range = {2'b00, req.addr[31:2]} >= 32'(MEM_WORDS);
    assign bad          = bad_f3 || out_of_range || misalign;
    // Access-size alignment is forced here, so the data path never sees a straddling lane
    assign lane = req.funct3[1] ? 2'b00 : req.funct3[0] ? {req.addr[1], 1'b0} : req.addr[1:0];

    assign shifted = mem.rdata >> {lane_q, 3'b000};
    assign ext     = f3_q[1:0] == 2'b00 ? {{24{~f3_q[2] & shifted[7]}}, shifted[7:0]} :
                     f3_q[1:0] == 2'b01 ? {{16{~f3_q[2] & shifted[15]}}, shifted[15:0]} : shifted;
    assign bmask_b = f3_q[0] ? (4'b0011 << lane_q) : (4'b0001 << lane_q);
    assign bmask   = {{8{bmask_b[3]}}, {8{bmask_b[2]}}, {8{bmask_b[1]}}, {8{bmask_b[0]}}};
    assign rep     = f3_q[0] ? {2{wd_q[15:0]}} : {4{wd_q[7:0]}};
    assign merged  = (mem.rdata & ~bmask) | (rep & bmask);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req.valid) state_nx = bad ? RESP : (req.we && req.funct3 == 3'b010) ? WRITE : ACCESS;
            ACCESS:  state_nx = we_q ? WRITE : RESP;
            WRITE:   state_nx = RESP;
            default: state_nx = IDLE;
        endcase
    end

    // Every output is gated by reset so an in-flight write cannot land during the reset cycle
    assign req.ready      = state == IDLE && !rst_i;
    assign req.resp_valid = state == RESP && !rst_i;
    assign req.resp_rdata = rst_i ? 32'h0 : rdata_q;
    assign req.resp_err   = err_q && !rst_i;
    assign mem.we         = state == WRITE && !rst_i;
    assign mem.addr       = rst_i ? 32'h0 : {2'b00, idx_q};
    assign mem.wdata      = rst_i ? 32'h0 : wd_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            idx_q   <= 30'h0;
            lane_q  <= 2'b00;
            wd_q    <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                we_q   <= req.we;
                f3_q   <= req.funct3;
                idx_q  <= req.addr[31:2];
                lane_q <= lane;
                wd_q   <= req.wdata;
                if (bad) begin
                    rdata_q <= 32'h0;
                    err_q   <= 1'b1;
                end
            end
            if (state == ACCESS) begin
                if (we_q) wd_q <= merged;
                else begin
                    rdata_q <= ext;
                    err_q   <= 1'b0;
                end
            end
            if (state == WRITE) begin
                rdata_q <= 32'h0;
                err_q   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench for load_store_unit against a behavioural data_memory.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic preload = 1'b1;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu_req_if rq();
    lsu_mem_if mb();

    load_store_unit #(.MEM_WORDS(256)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .req(rq),
        .mem(mb)
    );

    logic [31:0] mem [0:255];
    assign mb.rdata = mem[mb.addr[7:0]];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= (i == 4) ? 32'h88913416 : 32'h0;
        end else if (mb.we) mem[mb.addr[7:0]] <= mb.wdata;
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];
    exp_t e_pop;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rq.resp_valid) begin
            check("resp_pending", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                e_pop = sb.pop_front();
                check("resp_rdata", rq.resp_rdata, e_pop.rdata);
                check("resp_err", rq.resp_err, e_pop.err);
            end
        end
    end

    // exp_wcyc = 0 means the request must not write memory
    task automatic lsu_req(input string tag, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                           input int exp_wcyc, input logic [31:0] exp_waddr, input logic [31:0] exp_wdata);
        int n, wes, wcyc;
        logic [31:0] wa, wd;
        n = 0;
        while (!rq.ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, rq.ready, 1);
        rq.valid = 1'b1;
        rq.we = we;
        rq.funct3 = f3;
        rq.addr = addr;
        rq.wdata = wdata;
        sb.push_back('{exp_rdata, exp_err});
        @(posedge clk);
        #1 rq.valid = 1'b0;
        wes = 0;
        wcyc = 0;
        wa = 0;
        wd = 0;
        n = 0;
        while (n < 8) begin
            @(negedge clk);
            n++;
            if (mb.we) begin
                wes++;
                wcyc = n;
                wa = mb.addr;
                wd = mb.wdata;
            end
            if (rq.resp_valid) break;
        end
        check({tag, "_lat"}, n, exp_lat);
        check({tag, "_wcnt"}, wes, exp_wcyc != 0 ? 1 : 0);
        if (exp_wcyc != 0) begin
            check({tag, "_wcyc"}, wcyc, exp_wcyc);
            check({tag, "_waddr"}, wa, exp_waddr);
            check({tag, "_wdata"}, wd, exp_wdata);
        end
        @(negedge clk);
        check({tag, "_pulse"}, rq.resp_valid, 0);
        check({tag, "_ready_after"}, rq.ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rq.valid = 1'b0;
        rq.we = 1'b0;
        rq.funct3 = 3'b000;
        rq.addr = 32'h0;
        rq.wdata = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_ready", rq.ready, 0);
        check("rst_resp_valid", rq.resp_valid, 0);
        check("rst_mem_we", mb.we, 0);
        check("rst_rdata", rq.resp_rdata, 0);
        check("rst_err", rq.resp_err, 0);
        rst = 1'b0;
        preload = 1'b0;
        @(negedge clk);
        check("post_rst_ready", rq.ready, 1);

        lsu_req("lb_13",  0, 3'b000, 32'h13, 0, 32'hFFFFFF88, 0, 2, 0, 0, 0);
        lsu_req("lbu_13", 0, 3'b100, 32'h13, 0, 32'h00000088, 0, 2, 0, 0, 0);
        lsu_req("lb_10",  0, 3'b000, 32'h10, 0, 32'h00000016, 0, 2, 0, 0, 0);
        lsu_req("lh_12",  0, 3'b001, 32'h12, 0, 32'hFFFF8891, 0, 2, 0, 0, 0);
        lsu_req("lhu_10", 0, 3'b101, 32'h10, 0, 32'h00003416, 0, 2, 0, 0, 0);
        lsu_req("lh_10",  0, 3'b001, 32'h10, 0, 32'h00003416, 0, 2, 0, 0, 0);
        lsu_req("lw_10",  0, 3'b010, 32'h10, 0, 32'h88913416, 0, 2, 0, 0, 0);

        lsu_req("sb_11",  1, 3'b000, 32'h11, 32'h000000AB, 0, 0, 3, 2, 32'd4, 32'h8891AB16);
        lsu_req("lw_10b", 0, 3'b010, 32'h10, 0, 32'h8891AB16, 0, 2, 0, 0, 0);
        lsu_req("sh_22",  1, 3'b001, 32'h22, 32'hCAFEBEEF, 0, 0, 3, 2, 32'd8, 32'hBEEF0000);
        lsu_req("sw_24",  1, 3'b010, 32'h24, 32'h12345678, 0, 0, 2, 1, 32'd9, 32'h12345678);
        lsu_req("lw_20",  0, 3'b010, 32'h20, 0, 32'hBEEF0000, 0, 2, 0, 0, 0);
        lsu_req("lw_24",  0, 3'b010, 32'h24, 0, 32'h12345678, 0, 2, 0, 0, 0);
        lsu_req("lhu_22", 0, 3'b101, 32'h22, 0, 32'h0000BEEF, 0, 2, 0, 0, 0);
        lsu_req("lh_22",  0, 3'b001, 32'h22, 0, 32'hFFFFBEEF, 0, 2, 0, 0, 0);
        lsu_req("lbu_27", 0, 3'b100, 32'h27, 0, 32'h00000012, 0, 2, 0, 0, 0);

`ifdef LSU_MISALIGN_ERR_EN
        lsu_req("lw_16",  0, 3'b010, 32'h16, 0, 32'h0, 1, 1, 0, 0, 0);
        lsu_req("lw_12",  0, 3'b010, 32'h12, 0, 32'h0, 1, 1, 0, 0, 0);
        lsu_req("lhu_13", 0, 3'b101, 32'h13, 0, 32'h0, 1, 1, 0, 0, 0);
        lsu_req("sw_26",  1, 3'b010, 32'h26, 32'hDEADBEEF, 0, 1, 1, 0, 0, 0);
`else
        lsu_req("lw_16",  0, 3'b010, 32'h16, 0, 32'h00000000, 0, 2, 0, 0, 0);
        lsu_req("lw_12",  0, 3'b010, 32'h12, 0, 32'h8891AB16, 0, 2, 0, 0, 0);
        lsu_req("lhu_13", 0, 3'b101, 32'h13, 0, 32'h00008891, 0, 2, 0, 0, 0);
        lsu_req("sw_26",  1, 3'b010, 32'h26, 32'hDEADBEEF, 0, 0, 2, 1, 32'd9, 32'hDEADBEEF);
        lsu_req("lw_24b", 0, 3'b010, 32'h24, 0, 32'hDEADBEEF, 0, 2, 0, 0, 0);
`endif

        lsu_req("lw_400",   0, 3'b010, 32'h400, 0, 32'h0, 1, 1, 0, 0, 0);
        lsu_req("sb_400",   1, 3'b000, 32'h400, 32'h55, 0, 1, 1, 0, 0, 0);
        lsu_req("lw_3fc",   0, 3'b010, 32'h3FC, 0, 32'h0, 0, 2, 0, 0, 0);
        lsu_req("st_f3_3",  1, 3'b011, 32'h10, 32'h11223344, 0, 1, 1, 0, 0, 0);
        lsu_req("st_f3_4",  1, 3'b100, 32'h10, 32'h11223344, 0, 1, 1, 0, 0, 0);
        lsu_req("ld_f3_3",  0, 3'b011, 32'h10, 0, 32'h0, 1, 1, 0, 0, 0);
        lsu_req("ld_f3_6",  0, 3'b110, 32'h10, 0, 32'h0, 1, 1, 0, 0, 0);
        lsu_req("lw_after", 0, 3'b010, 32'h10, 0, 32'h8891AB16, 0, 2, 0, 0, 0);

        // SH aborted by a reset raised in its WRITE cycle
        rq.valid = 1'b1;
        rq.we = 1'b1;
        rq.funct3 = 3'b001;
        rq.addr = 32'h10;
        rq.wdata = 32'h00007777;
        check("abort_ready", rq.ready, 1);
        @(posedge clk);
        #1 rq.valid = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_we_before", mb.we, 1);
        check("abort_wdata_before", mb.wdata, 32'h88917777);
        rst = 1'b1;
        #1;
        check("abort_we_gated", mb.we, 0);
        check("abort_ready_gated", rq.ready, 0);
        @(negedge clk);
        check("abort_no_resp", rq.resp_valid, 0);
        rst = 1'b0;
        @(negedge clk);
        check("abort_ready_after", rq.ready, 1);
        check("abort_no_resp2", rq.resp_valid, 0);
        check("abort_word4", mem[4], 32'h8891AB16);
        lsu_req("lw_final", 0, 3'b010, 32'h10, 0, 32'h8891AB16, 0, 2, 0, 0, 0);
        check("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
